mips_multicycle_ctrl: RTL and testbench

//  Multi-cycle control FSM that drives the single-cycle MIPS datapath's control inputs.

---
 rtl/mips_ctrl_pkg.sv | 26 ++
 rtl/mips_multicycle_ctrl_if.sv | 31 +++
 rtl/alu_decoder.sv | 34 +++
 rtl/mips_multicycle_ctrl.sv | 80 ++++++++
 tb/tb_mips_multicycle_ctrl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcode/funct encodings, ALUcontrol codes and FSM state encoding for the multicycle MIPS controller
package mips_ctrl_pkg;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  typedef enum logic [3:0] {
    S_IDLE, S_DECODE, S_EXEC, S_WB_ALU, S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_TRAP
  } state_t;
endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if: instruction handshake plus datapath control bundle
//  master: instruction source / datapath side (drives inst_valid, INST, is_Zero)
//  slave : controller side (drives inst_ready, inst_q, strobes, ALUcontrol, status)
interface mips_multicycle_ctrl_if #(parameter int CNT_W = 16);
  logic             inst_valid;
  logic [31:0]      INST;
  logic             inst_ready;
  logic             is_Zero;
  logic [31:0]      inst_q;
  logic             regDst;
  logic             regWrite;
  logic             ALUSrc;
  logic             memWrite;
  logic             memRead;
  logic             memtoReg;
  logic [3:0]       ALUcontrol;
  logic             branch_taken;
  logic             done;
  logic             illegal_op;
  logic [CNT_W-1:0] ret_cnt;
  modport master (
    output inst_valid, INST, is_Zero,
    input  inst_ready, inst_q, regDst, regWrite, ALUSrc, memWrite, memRead, memtoReg,
           ALUcontrol, branch_taken, done, illegal_op, ret_cnt
  );
  modport slave (
    input  inst_valid, INST, is_Zero,
    output inst_ready, inst_q, regDst, regWrite, ALUSrc, memWrite, memRead, memtoReg,
           ALUcontrol, branch_taken, done, illegal_op, ret_cnt
  );
endinterface

// File: rtl/alu_decoder.sv
// alu_decoder: (opcode, funct) -> ALUcontrol and legal flag; unknown opcode or R funct is illegal
//  in : opcode[5:0], funct[5:0]
//  out: alu_ctrl[3:0], legal
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctrl,
  output logic       legal
);
  always_comb begin
    alu_ctrl = ALU_AND;
    legal = 1'b1;
    case (opcode)
      OP_R:
        case (funct)
          FN_ADD:  alu_ctrl = ALU_ADD;
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          FN_NOR:  alu_ctrl = ALU_NOR;
          default: legal = 1'b0;
        endcase
      OP_ADDI, OP_LW, OP_SW: alu_ctrl = ALU_ADD;
      OP_ANDI: alu_ctrl = ALU_AND;
      OP_ORI:  alu_ctrl = ALU_OR;
      OP_SLTI: alu_ctrl = ALU_SLT;
      OP_BEQ:  alu_ctrl = ALU_SUB;
      default: legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle control FSM driving a single-cycle MIPS datapath
//  CLK, RST_N (async active-low); bus (slave modport): instruction valid/ready handshake,
//  latched IR (inst_q), datapath strobes, ALUcontrol, branch_taken/done pulses, illegal_op, ret_cnt.
//  Params: MEM_LAT cycles per memory access (>=1), CNT_W retired-counter width.
//  Define CTRL_ILLEGAL_TRAP_EN to trap on illegal opcodes; otherwise they retire as NOPs.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int CNT_W = 16
) (
  input logic CLK,
  input logic RST_N,
  mips_multicycle_ctrl_if.slave bus
);
  localparam int MW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
  state_t state_q, state_d;
  logic [31:0] ir;
  logic [MW-1:0] mem_cnt;
  logic [CNT_W-1:0] ret_cnt;
  logic [3:0] dec_alu;
  logic legal, is_r, is_beq, ready, done, in_mem, mem_last, alu_phase, nop_ret;
  state_t ill_next;
  alu_decoder u_dec (.opcode(ir[31:26]), .funct(ir[5:0]), .alu_ctrl(dec_alu), .legal(legal));
  assign is_r = ir[31:26] == OP_R;
  assign is_beq = ir[31:26] == OP_BEQ;
  assign ready = state_q == S_IDLE;
  assign in_mem = state_q == S_MEM_RD || state_q == S_MEM_WR;
  assign mem_last = mem_cnt == MW'(MEM_LAT - 1);
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign ill_next = S_TRAP;
  assign nop_ret = 1'b0;
  assign bus.illegal_op = state_q == S_TRAP;
`else
  assign ill_next = S_IDLE;
  assign nop_ret = state_q == S_DECODE && !legal;
  assign bus.illegal_op = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = bus.inst_valid ? S_DECODE : S_IDLE;
      S_DECODE: state_d = legal ? S_EXEC : ill_next;
      S_EXEC:   state_d = ir[31:26] == OP_LW ? S_MEM_RD :
                          ir[31:26] == OP_SW ? S_MEM_WR : is_beq ? S_BRANCH : S_WB_ALU;
      S_MEM_RD: state_d = mem_last ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR: state_d = mem_last ? S_IDLE : S_MEM_WR;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      ir <= '0;
      mem_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (ready && bus.inst_valid) ir <= bus.INST;
      mem_cnt <= in_mem && !mem_last ? mem_cnt + 1'b1 : '0;
      if (done) ret_cnt <= ret_cnt + 1'b1;
    end
  end
  // ALU select and operand source stay put from EXEC to the end of the path so address/result are stable
  assign alu_phase = state_q inside {S_EXEC, S_WB_ALU, S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH};
  assign done = state_q inside {S_WB_ALU, S_WB_MEM, S_BRANCH} || (state_q == S_MEM_WR && mem_last) || nop_ret;
  assign bus.inst_ready = ready;
  assign bus.inst_q = ir;
  assign bus.ALUcontrol = alu_phase ? dec_alu : 4'b0000;
  assign bus.ALUSrc = alu_phase && !is_r && !is_beq;
  assign bus.regDst = (state_q == S_EXEC || state_q == S_WB_ALU) && is_r;
  assign bus.regWrite = state_q == S_WB_ALU || state_q == S_WB_MEM;
  assign bus.memtoReg = state_q == S_WB_MEM;
  assign bus.memRead = state_q == S_MEM_RD;
  assign bus.memWrite = state_q == S_MEM_WR;
  assign bus.branch_taken = state_q == S_BRANCH && bus.is_Zero;
  assign bus.done = done;
  assign bus.ret_cnt = ret_cnt;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: scoreboard bench; per-instruction expectations from an instruction-level model
module tb_mips_multicycle_ctrl;
  localparam int L = 2;
  localparam int CW = 16;
  logic CLK = 1'b0;
  logic RST_N = 1'b1;
  always #5 CLK = ~CLK;
  mips_multicycle_ctrl_if #(.CNT_W(CW)) bus ();
  mips_multicycle_ctrl #(.MEM_LAT(L), .CNT_W(CW)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));
  typedef struct {
    int lat, rw, mr, mw, m2r, bt, alu, src, dst, dstw, srcd, cnt;
    logic [31:0] inst;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int vec = 0, err = 0, retired = 0;
  int cyc, rw, mr, mw, m2r, bt, alu, src, dst, dstw;
  logic [31:0] inst_s;
  bit active = 0, chk_rdy = 0;
  logic [5:0] fns[6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27};
  logic [5:0] iops[4] = '{6'h08, 6'h0c, 6'h0d, 6'h0a};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    vec++;
    if (act !== want) begin
      err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
    end
  endtask

  // what one instruction should do over its whole lifetime, from the ISA-level rules
  function automatic exp_t model(input logic [31:0] in, input logic z, input int cnt);
    exp_t r;
    logic [5:0] op, fn;
    r = '{default: 0};
    op = in[31:26];
    fn = in[5:0];
    r.inst = in;
    r.cnt = cnt;
    r.lat = 1;
    if (op == 6'h00 && fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27}) begin
      r.lat = 3; r.rw = 1; r.dst = 1; r.dstw = 1;
      r.alu = fn == 6'h20 ? 2 : fn == 6'h22 ? 6 : fn == 6'h24 ? 0 : fn == 6'h25 ? 1 : fn == 6'h2a ? 7 : 12;
    end else if (op inside {6'h08, 6'h0c, 6'h0d, 6'h0a}) begin
      r.lat = 3; r.rw = 1; r.src = 1; r.srcd = 1;
      r.alu = op == 6'h08 ? 2 : op == 6'h0c ? 0 : op == 6'h0d ? 1 : 7;
    end else if (op == 6'h23) begin
      r.lat = 3 + L; r.rw = 1; r.mr = L; r.m2r = 1; r.alu = 2; r.src = 1; r.srcd = 1;
    end else if (op == 6'h2b) begin
      r.lat = 2 + L; r.mw = L; r.alu = 2; r.src = 1; r.srcd = 1;
    end else if (op == 6'h04) begin
      r.lat = 3; r.bt = int'(z); r.alu = 6;
    end
    return r;
  endfunction

  task automatic issue(input logic [31:0] in, input logic z, input bit expect_done);
    int n = 0;
    while (bus.inst_ready !== 1'b1 && n < 200) begin @(posedge CLK); #1; n++; end
    if (n >= 200) begin
      vec++; err++;
      $display("FAIL issue_timeout: inst_ready=%b, expected 1", bus.inst_ready);
      return;
    end
    if ($urandom_range(0, 3) == 0) begin
      bus.inst_valid = 1'b0;
      repeat ($urandom_range(1, 3)) begin @(posedge CLK); #1; end
    end
    bus.inst_valid = 1'b1;
    bus.INST = in;
    bus.is_Zero = z;
    if (expect_done) begin sb.push_back(model(in, z, retired)); retired++; end
    @(posedge CLK); #1;
    bus.inst_valid = 1'b1;
    bus.INST = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (bus.inst_ready !== 1'b1 && n < 200) begin @(posedge CLK); #1; n++; end
    bus.inst_valid = 1'b0;
    while (sb.size() > 0 && n < 400) begin @(posedge CLK); #1; n++; end
    if (sb.size() > 0) begin
      vec++; err++;
      $display("FAIL drain: %0d instructions never retired, expected 0", sb.size());
      sb.delete();
    end
  endtask

  always @(negedge CLK) begin
    if (!RST_N) begin
      active = 0;
      chk_rdy = 0;
    end else begin
      if (chk_rdy) begin chk("ready_after_done", 32'(bus.inst_ready), 1); chk_rdy = 0; end
      if (active) begin
        cyc++;
        rw += int'(bus.regWrite);
        mr += int'(bus.memRead);
        mw += int'(bus.memWrite);
        m2r += int'(bus.memtoReg);
        bt += int'(bus.branch_taken);
        if (cyc == 1) inst_s = bus.inst_q;
        if (cyc == 2) begin alu = int'(bus.ALUcontrol); src = int'(bus.ALUSrc); dst = int'(bus.regDst); end
        if (bus.regWrite) dstw = int'(bus.regDst);
        if (bus.done) begin
          if (sb.size() == 0) begin
            vec++; err++;
            $display("FAIL unexpected_done: done=1 with no instruction outstanding, expected 0");
          end else begin
            e = sb.pop_front();
            chk("latency", cyc, e.lat);
            chk("regWrite_cycles", rw, e.rw);
            chk("memRead_cycles", mr, e.mr);
            chk("memWrite_cycles", mw, e.mw);
            chk("memtoReg_cycles", m2r, e.m2r);
            chk("branch_taken_cycles", bt, e.bt);
            chk("exec_ALUcontrol", alu, e.alu);
            chk("exec_ALUSrc", src, e.src);
            chk("exec_regDst", dst, e.dst);
            chk("wb_regDst", dstw, e.dstw);
            chk("ALUSrc_at_done", 32'(bus.ALUSrc), e.srcd);
            chk("inst_q", inst_s, e.inst);
            chk("ret_cnt", 32'(bus.ret_cnt), e.cnt & 32'hFFFF);
          end
          active = 0;
          chk_rdy = 1;
        end else if (cyc > 40) begin
          vec++; err++;
          $display("FAIL done_timeout: no done after %0d cycles, expected done", cyc);
          active = 0;
        end
      end else if (bus.done) begin
        vec++; err++;
        $display("FAIL spurious_done: done=1 while idle, expected 0");
      end
      if (bus.inst_valid && bus.inst_ready) begin
        active = 1; cyc = 0; rw = 0; mr = 0; mw = 0; m2r = 0; bt = 0; alu = 0; src = 0; dst = 0; dstw = 0;
      end
    end
  end

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_strobes"}, 32'({bus.regDst, bus.regWrite, bus.ALUSrc, bus.memWrite, bus.memRead,
                               bus.memtoReg, bus.branch_taken, bus.done, bus.illegal_op}), 0);
    chk({tag, "_ALUcontrol"}, 32'(bus.ALUcontrol), 0);
    chk({tag, "_inst_ready"}, 32'(bus.inst_ready), 1);
    chk({tag, "_inst_q"}, bus.inst_q, 0);
    chk({tag, "_ret_cnt"}, 32'(bus.ret_cnt), 0);
  endtask

  initial begin
    logic [31:0] r, in;
    int k, n;
    bus.inst_valid = 1'b0;
    bus.INST = '0;
    bus.is_Zero = 1'b0;
    #2 RST_N = 1'b0;
    #10;
    chk_idle_outputs("reset");
    @(posedge CLK); #3 RST_N = 1'b1;
    @(posedge CLK); #1;
    issue(32'h00221820, 1'b0, 1);
    issue(32'h8C250008, 1'b0, 1);
    issue(32'hAC250004, 1'b0, 1);
    issue(32'h10220003, 1'b1, 1);
    issue(32'h10220003, 1'b0, 1);
`ifndef CTRL_ILLEGAL_TRAP_EN
    issue(32'hFC000000, 1'b0, 1);
`endif
    for (int i = 0; i < 300; i++) begin
      r = $urandom;
`ifdef CTRL_ILLEGAL_TRAP_EN
      k = $urandom_range(0, 5);
`else
      k = $urandom_range(0, 7);
`endif
      case (k)
        0, 1: in = {6'h00, r[25:6], fns[$urandom_range(0, 5)]};
        2: in = {iops[$urandom_range(0, 3)], r[25:0]};
        3: in = {6'h23, r[25:0]};
        4: in = {6'h2b, r[25:0]};
        5: in = {6'h04, r[25:0]};
        6: in = {6'h00, r[25:0]};
        default: in = r;
      endcase
      issue(in, 1'($urandom_range(0, 1)), 1);
    end
    drain();
    issue(32'hAC250004, 1'b0, 1);
    n = 0;
    while (bus.memWrite !== 1'b1 && n < 20) begin @(posedge CLK); #1; n++; end
    chk("sw_reached_mem_wr", 32'(bus.memWrite), 1);
    #2 RST_N = 1'b0;
    #1;
    chk("async_rst_memWrite", 32'(bus.memWrite), 0);
    chk("async_rst_ret_cnt", 32'(bus.ret_cnt), 0);
    chk("async_rst_ready", 32'(bus.inst_ready), 1);
    sb.delete();
    retired = 0;
    bus.inst_valid = 1'b0;
    @(posedge CLK); #3 RST_N = 1'b1;
    @(posedge CLK); #1;
    chk_idle_outputs("post_reset");
    issue(32'h00221820, 1'b0, 1);
    drain();
`ifdef CTRL_ILLEGAL_TRAP_EN
    issue(32'hFC000000, 1'b0, 0);
    repeat (6) @(posedge CLK);
    #1;
    chk("trap_illegal_op", 32'(bus.illegal_op), 1);
    chk("trap_inst_ready", 32'(bus.inst_ready), 0);
    chk("trap_strobes", 32'({bus.regWrite, bus.memWrite, bus.memRead, bus.done}), 0);
    bus.inst_valid = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    chk("trap_cleared", 32'(bus.illegal_op), 0);
    @(posedge CLK); #3 RST_N = 1'b1;
    @(posedge CLK); #1;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
